// File: rtl/iahb_lite_mst.sv
// AHB-lite instruction/data bus master: turns a single valid/ready client request
// stream into pipelined AHB-lite transfers and returns one ordered response per request.
module iahb_lite_mst (
  input  logic        pll_core_cpuclk,
  input  logic        pad_cpu_rst_b,
  input  logic        pad_biu_bigend_b,
  // Client side: a request is taken on a rising edge with req_vld && req_rdy;
  // exactly one rsp_vld pulse is returned per taken request, in acceptance order.
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_vld,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mst_yy_haddr,
  output logic [1:0]  mst_yy_htrans,
  output logic [2:0]  mst_yy_hsize,
  output logic        mst_yy_hwrite,
  output logic [31:0] mst_yy_hwdata,
  input  logic [31:0] yy_mst_hrdata,
  input  logic        yy_mst_hready,
  input  logic [1:0]  yy_mst_hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  logic        ap_pend;
  logic        err_replay;
  logic        dp_vld;
  logic        lcl_err_pend;
  logic [31:0] ap_wdata;
  logic [1:0]  dp_addr;
  logic [2:0]  dp_size;
  logic        dp_write;

  logic        misalign;
  logic        pipe_empty;
  logic        acc_al;
  logic        acc_mis;
  logic        hresp_err;
  logic        err_cyc1;
  logic        advance;
  logic [31:0] wdata_rep;
  logic [1:0]  rd_lane;
  logic [31:0] rd_ext;

  always_comb begin
    misalign = 1'b0;
    if (req_size > 3'd2)                             misalign = 1'b1;
    else if (req_size == 3'd1 && req_addr[0])        misalign = 1'b1;
    else if (req_size == 3'd2 && req_addr[1:0] != 2'd0) misalign = 1'b1;
  end

  assign pipe_empty = !ap_pend && !dp_vld;
  // Misaligned requests never reach the bus, so they wait for an empty pipeline to keep order.
  assign req_rdy    = pad_cpu_rst_b && yy_mst_hready && !err_replay && !lcl_err_pend &&
                      (!misalign || pipe_empty);
  assign acc_al     = req_vld && req_rdy && !misalign;
  assign acc_mis    = req_vld && req_rdy && misalign;

  assign hresp_err  = (yy_mst_hresp == HRESP_ERROR);
  assign err_cyc1   = dp_vld && hresp_err && !yy_mst_hready;
  assign advance    = yy_mst_hready && ap_pend && !err_replay;

  // A pending address phase is withdrawn to IDLE for both error cycles and replayed afterwards.
  assign mst_yy_htrans = (ap_pend && !err_replay && !err_cyc1) ? HTRANS_NONSEQ : HTRANS_IDLE;

  always_comb begin
    case (req_size)
      3'd0:    wdata_rep = {4{req_wdata[7:0]}};
      3'd1:    wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  // Big-endian lane numbering is the bitwise complement of the little-endian one.
  always_comb begin
    rd_lane = 2'd0;
    rd_ext  = yy_mst_hrdata;
    case (dp_size)
      3'd0: begin
        rd_lane = pad_biu_bigend_b ? dp_addr : ~dp_addr;
        rd_ext  = (yy_mst_hrdata >> {rd_lane, 3'b000}) & 32'h0000_00ff;
      end
      3'd1: begin
        rd_lane = pad_biu_bigend_b ? {dp_addr[1], 1'b0} : {~dp_addr[1], 1'b0};
        rd_ext  = (yy_mst_hrdata >> {rd_lane, 3'b000}) & 32'h0000_ffff;
      end
      default: rd_ext = yy_mst_hrdata;
    endcase
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      ap_pend       <= 1'b0;
      err_replay    <= 1'b0;
      dp_vld        <= 1'b0;
      lcl_err_pend  <= 1'b0;
      ap_wdata      <= 32'd0;
      dp_addr       <= 2'd0;
      dp_size       <= 3'd0;
      dp_write      <= 1'b0;
      mst_yy_haddr  <= 32'd0;
      mst_yy_hsize  <= 3'd0;
      mst_yy_hwrite <= 1'b0;
      mst_yy_hwdata <= 32'd0;
      rsp_vld       <= 1'b0;
      rsp_rdata     <= 32'd0;
      rsp_err       <= 1'b0;
    end else begin
      rsp_vld      <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
      lcl_err_pend <= 1'b0;
      // Sticky: a replay already armed keeps its bookkeeping.
      if (err_cyc1 && ap_pend && !err_replay) err_replay <= 1'b1;
      if (yy_mst_hready) begin
        if (err_replay) err_replay <= 1'b0;
        if (dp_vld) begin
          rsp_vld   <= 1'b1;
          rsp_err   <= hresp_err;
          rsp_rdata <= (!dp_write && !hresp_err) ? rd_ext : 32'd0;
        end
        dp_vld <= advance;
        if (advance) begin
          dp_addr       <= mst_yy_haddr[1:0];
          dp_size       <= mst_yy_hsize;
          dp_write      <= mst_yy_hwrite;
          mst_yy_hwdata <= ap_wdata;
        end
        if (acc_al) begin
          ap_pend       <= 1'b1;
          mst_yy_haddr  <= req_addr;
          mst_yy_hsize  <= req_size;
          mst_yy_hwrite <= req_write;
          ap_wdata      <= wdata_rep;
        end else if (!err_replay) begin
          ap_pend <= 1'b0;
        end
        if (acc_mis) begin
          rsp_vld      <= 1'b1;
          rsp_err      <= 1'b1;
          rsp_rdata    <= 32'd0;
          lcl_err_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/iahb_lite_mst.md
IAHB_LITE_MST -- requirements
Module: iahb_lite_mst

Interface
REQ-001 SHALL have input pll_core_cpuclk, 1 bit: clock; all state changes on its rising edge.
REQ-002 SHALL have input pad_cpu_rst_b, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have input pad_biu_bigend_b, 1 bit: 0 = big-endian, 1 = little-endian; static during operation.
REQ-004 SHALL have input req_vld, 1 bit: client request valid.
REQ-005 SHALL have output req_rdy, 1 bit: request accepted when req_vld && req_rdy at a rising edge.
REQ-006 SHALL have inputs req_write (1 bit), req_addr (32 bits), req_size (3 bits) and req_wdata (32 bits, right-justified).
REQ-007 SHALL have outputs rsp_vld (1 bit, one-cycle pulse), rsp_rdata (32 bits, right-justified) and rsp_err (1 bit).
REQ-008 SHALL have AHB-lite outputs mst_yy_haddr (32), mst_yy_htrans (2), mst_yy_hsize (3), mst_yy_hwrite (1) and mst_yy_hwdata (32).
REQ-009 SHALL have AHB-lite inputs yy_mst_hrdata (32), yy_mst_hready (1) and yy_mst_hresp (2); hresp 00 = OKAY, 01 = ERROR.

Function
REQ-010 SHALL use a two-stage pipeline: at most one address phase plus one data phase outstanding.
REQ-011 SHALL hold all address-phase outputs and hwdata stable while yy_mst_hready=0.
REQ-012 SHALL drive req_rdy = yy_mst_hready && !err_replay && !lcl_err_pend for aligned requests.
REQ-013 SHALL load the address-phase registers on an accepted aligned request (hready=1): haddr=req_addr, hsize=req_size, hwrite=req_write, htrans=NONSEQ (10) in the next cycle.
REQ-014 SHALL drive htrans=IDLE (00) on an edge where hready=1 and no request is accepted.
REQ-015 SHALL advance the address phase into the data phase on an edge where hready=1 and htrans=NONSEQ, driving mst_yy_hwdata from the captured req_wdata.
REQ-016 SHALL lane-replicate hwdata: byte as {4{b}}, half as {2{h}}, word unchanged.
REQ-017 SHALL pulse rsp_vld for one cycle in the cycle after hready=1 ends an active data phase.
REQ-018 SHALL set rsp_rdata for that response to the read data extracted from hrdata and zero-extended; rsp_rdata SHALL be 0 for writes.
REQ-019 SHALL select read lanes: little-endian byte lane = addr[1:0], half lane = addr[1]; big-endian byte lane = 3-addr[1:0], half lane = 1-addr[1].
REQ-020 SHALL treat these requests as misaligned: size=001 with addr[0]=1; size=010 with addr[1:0]!=0; size>010.
REQ-021 SHALL accept a misaligned request only when the pipeline is empty; it SHALL NOT be issued on AHB, and rsp_vld with rsp_err=1 and rsp_rdata=0 SHALL follow in the next cycle.
REQ-022 SHALL, on the first ERROR cycle (hresp=01, hready=0) with a NONSEQ pending in the address phase, drive htrans=IDLE while keeping haddr, hsize and hwrite, and set err_replay.
REQ-023 SHALL, on the second ERROR cycle (hready=1), report rsp_err=1 for the failed transfer.
REQ-024 SHALL, while err_replay=1, re-drive NONSEQ with the held address in the cycle after the second ERROR cycle, then clear err_replay.
REQ-025 SHALL respond strictly in acceptance order, including misaligned and replayed requests.
REQ-026 SHALL support back-to-back accepted requests with hready=1 at a throughput of 1 transfer/cycle and a request-to-response latency of 2 cycles.
REQ-027 SHALL keep the cancelled transfer's replay bookkeeping unchanged if a second ERROR occurs during replay (errors are sticky per transfer).

Reset
REQ-028 SHALL, with pad_cpu_rst_b low, immediately force: htrans=IDLE, haddr=0, hsize=0, hwrite=0, hwdata=0, rsp_vld=0, rsp_rdata=0, rsp_err=0, and clear err_replay and data-phase valid.
REQ-029 SHALL drop any outstanding transfer on reset assertion mid-operation, issue no response for it, and drive req_rdy=0 while reset is asserted.

Verification
REQ-030 SHALL pass: LE read byte addr 0x1003, hrdata 0xAABBCCDD, hready=1 -> rsp_vld 2 cycles after accept, rsp_rdata=0x000000AA, rsp_err=0.
REQ-031 SHALL pass: BE write half addr 0x2002, wdata 0x1234 -> hwdata=0x12341234, hsize=001, hwrite=1, htrans=NONSEQ for exactly 1 cycle.
REQ-032 SHALL pass: three back-to-back word reads with hready held low for 2 cycles on the second data phase -> haddr/hwdata stable, 3 in-order responses, no duplicate.
REQ-033 SHALL pass: write to 0x3000 with hresp=ERROR (2-cycle) and a read of 0x3004 pending -> htrans=IDLE on error cycle 1, rsp_err=1 for the write, and 0x3004 re-issued as NONSEQ with an OKAY response.
REQ-034 SHALL pass: word request addr 0x0002 -> no AHB activity, rsp_vld=1 with rsp_err=1 and rsp_rdata=0 next cycle.
REQ-035 SHALL pass: reset asserted while a data phase is stalled -> all outputs at their reset values asynchronously, no rsp_vld after release.
